// File: rtl/serial_subtractor_if.sv
// Operand and result valid/ready channels of the bit-serial subtractor.
// The producer/consumer side uses master; the subtractor itself uses slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  io
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_ak;
    logic             w_bk;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_result;

    // Operands shift right, so bit 0 is always the bit being processed;
    // on the final edge it holds the operand sign bits.
    assign w_ak      = r_a[0];
    assign w_bk      = r_b[0];
    assign w_d       = w_ak ^ w_bk ^ r_br;
    assign w_br_next = (~w_ak & w_bk) | (~(w_ak ^ w_bk) & r_br);
    assign w_result  = {w_d, r_shift[WIDTH-1:1]};

    // NOTE: every state register uses non-blocking assignment so all of them
    // update from the same pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_shift     <= '0;
            r_br        <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io.in_valid) begin
                        r_a        <= io.a;
                        r_b        <= io.b;
                        r_br       <= io.bin;
                        r_shift    <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_br    <= w_br_next;
                    r_shift <= w_result;
                    if (r_cnt == LAST) begin
                        r_diff      <= w_result;
                        r_bout      <= w_br_next;
                        r_ovf       <= (w_ak ^ w_bk) & (w_d ^ w_ak);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign io.in_ready  = r_in_ready;
    assign io.out_valid = r_out_valid;
    assign io.diff      = r_diff;
    assign io.bout      = r_bout;
    assign io.ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases with literal
// expectations plus a random stream compared against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           t_acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rdy_mode = 1;   // 0: hold out_ready low, 1: high, 2: random
    logic prev_ov  = 1'b0;
    exp_t q[$];

    serial_subtractor_if #(.WIDTH(W)) dut_if ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dut_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        exp_t       e;
        logic [W:0] u;
        int         sd;
        u      = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
        sd     = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
        e.diff = u[W-1:0];
        e.bout = u[W];
        e.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        e.t_acc = 0;
        return e;
    endfunction

    initial begin
        dut_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dut_if.out_ready = 1'b0;
                1:       dut_if.out_ready = 1'b1;
                default: dut_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: every valid result cycle is checked against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            check("ready_valid_exclusive", 32'(dut_if.in_ready & dut_if.out_valid), 32'd0);
            if (dut_if.out_valid) begin
                if (q.size() == 0) begin
                    check("result_without_accept", 32'(dut_if.out_valid), 32'd0);
                end else begin
                    check("model_diff", 32'(dut_if.diff), 32'(q[0].diff));
                    check("model_bout", 32'(dut_if.bout), 32'(q[0].bout));
                    check("model_ovf", 32'(dut_if.ovf), 32'(q[0].ovf));
                    if (!prev_ov) check("latency", 32'(cyc - q[0].t_acc), 32'(W));
                    if (dut_if.out_ready) void'(q.pop_front());
                end
            end
            if (dut_if.in_valid && dut_if.in_ready) begin
                e       = model(dut_if.a, dut_if.b, dut_if.bin);
                e.t_acc = cyc + 1;
                q.push_back(e);
            end
            prev_ov = dut_if.out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        int guard = 0;
        @(posedge clk);
        #2;
        while (!dut_if.in_ready && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'(dut_if.in_ready), 32'd1);
        dut_if.in_valid = 1'b1;
        dut_if.a        = ia;
        dut_if.b        = ib;
        dut_if.bin      = ibin;
        @(posedge clk);
        #2;
        dut_if.in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        @(negedge clk);
        while (!dut_if.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dut_if.out_valid) check("result_timeout", 32'(dut_if.out_valid), 32'd1);
    endtask

    task automatic directed(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ibin, input logic [W-1:0] ed, input logic eb, input logic eo);
        issue(ia, ib, ibin);
        wait_result();
        check({name, "_diff"}, 32'(dut_if.diff), 32'(ed));
        check({name, "_bout"}, 32'(dut_if.bout), 32'(eb));
        check({name, "_ovf"}, 32'(dut_if.ovf), 32'(eo));
        if (rdy_mode == 1) begin
            @(posedge clk);
            #2;
            check({name, "_in_ready_after"}, 32'(dut_if.in_ready), 32'd1);
            check({name, "_out_valid_after"}, 32'(dut_if.out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] held_diff;
        int           n;

        rst_n           = 1'b1;
        dut_if.in_valid = 1'b0;
        dut_if.a        = '0;
        dut_if.b        = '0;
        dut_if.bin      = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(dut_if.in_ready), 32'd1);
        check("reset_out_valid", 32'(dut_if.out_valid), 32'd0);
        check("reset_diff", 32'(dut_if.diff), 32'd0);
        check("reset_bout", 32'(dut_if.bout), 32'd0);
        check("reset_ovf", 32'(dut_if.ovf), 32'd0);
        #1 rst_n = 1'b1;

        directed("basic", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        directed("zero_minus_one", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        directed("equal_with_bin", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        directed("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        directed("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Backpressure, with input noise while the operation runs.
        rdy_mode = 0;
        issue(8'hC3, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dut_if.in_valid = ~dut_if.in_valid;
            dut_if.a        = W'($urandom);
            @(posedge clk);
            #2;
        end
        dut_if.in_valid = 1'b0;
        wait_result();
        check("bp_diff", 32'(dut_if.diff), 32'h87);
        held_diff = dut_if.diff;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid_hold", 32'(dut_if.out_valid), 32'd1);
            check("bp_diff_stable", 32'(dut_if.diff), 32'(held_diff));
            check("bp_in_ready_low", 32'(dut_if.in_ready), 32'd0);
        end
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #2;
        check("bp_released_in_ready", 32'(dut_if.in_ready), 32'd1);

        // Reset during RUN aborts the transaction.
        issue(8'h55, 8'h0F, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(dut_if.in_ready), 32'd1);
        check("abort_out_valid", 32'(dut_if.out_valid), 32'd0);
        check("abort_diff", 32'(dut_if.diff), 32'd0);
        check("abort_bout", 32'(dut_if.bout), 32'd0);
        check("abort_ovf", 32'(dut_if.ovf), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        directed("after_abort", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);

        // Random stream with random consumer backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 1;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || dut_if.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_results", 32'(q.size()), 32'd0);
        check("drain_out_valid", 32'(dut_if.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial unsigned/two's-complement subtractor: computes a − b − bin, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Arithmetic inverse of the ripple-carry adder datapath, for area-constrained paths where the latency is acceptable.
- Operands are accepted and results returned through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, bin valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  diff, bout, ovf valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  borrow out; 1 iff unsigned a < b + bin
- ovf  output  1  signed overflow of a − b − bin, operands treated as two's-complement

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit counter=0, internal borrow=0, operand/shift registers=0.
- Reset output values: in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block captures a, b, and bin into internal registers, clears the counter, and moves to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0; in_valid, a, b, and bin are ignored.
  - Each edge processes bit k = counter, k = 0..WIDTH−1:
    - d_k = a_k ^ b_k ^ br
    - br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br)
  - d_k is shifted into the result register from the MSB side; the counter increments.
  - The edge that processes bit WIDTH−1 loads diff, bout (= final br_next), and ovf (= a[W−1] ^ b[W−1]) & (diff[W−1] ^ a[W−1]), where diff[W−1] is the final result bit. That edge also moves the FSM to DONE.
- Latency: operands accepted at edge T; out_valid=1 after edge T+WIDTH, so it is visible during cycle T+WIDTH.
- DONE:
  - out_valid=1; diff, bout, and ovf are stable.
  - Hold indefinitely while out_ready=0.
  - On an edge with out_ready=1: out_valid→0, state→IDLE, in_ready→1.
  - No same-cycle accept of new operands; minimum issue interval is WIDTH+2 cycles.
- diff, bout, and ovf are registered outputs. They update only on the completion edge and otherwise hold their last value, including through IDLE.
- out_ready is ignored outside DONE.
- Counter width is clog2(WIDTH); the counter never wraps past WIDTH−1 within a transaction.
- Reset asserted mid-RUN or in DONE aborts the transaction immediately; all outputs return to their reset values. No partial result is ever presented.
- No X propagation from a, b, or bin while not in IDLE.

Test Plan:
- Reset, then WIDTH=8, a=0x5A, b=0x23, bin=0, out_ready=1 → out_valid exactly 8 cycles after accept; diff=0x37, bout=0, ovf=0; in_ready high the cycle after the handshake.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1.
- Signed overflow: a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0. Toggle in_valid and a during RUN → result unaffected (a=0xC3, b=0x3C → diff=0x87).
- Drop rst_n at cycle 4 of RUN → in_ready=1, out_valid=0, diff/bout/ovf=0 immediately. After release, a new transaction a=0x01, b=0x01, bin=0 → diff=0x00, bout=0.
- Randomized back-to-back stream (1000 operand sets, random out_ready), checked against a − b − bin reference → zero mismatches; every accepted transaction returns exactly one result.
